// File: rtl/tape_ram_pkg.sv
// Shared types and helpers for the dual-port tape memory.
// Byte-lane merge works on a wide container; callers cast in and out.
package tape_ram_pkg;

   typedef enum logic {
      ST_INIT,
      ST_IDLE
   } state_e;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int MAX_DW          = 1024;

   // we is a per-bit mask already expanded from the byte strobes
   function automatic logic [MAX_DW-1:0] merge_word(
      input logic [MAX_DW-1:0] old_w,
      input logic [MAX_DW-1:0] new_w,
      input logic [MAX_DW-1:0] we
   );
      return (old_w & ~we) | (new_w & we);
   endfunction

endpackage

// File: rtl/tape_ram_init_ctrl.sv
// Init-sweep controller: walks every address once after reset or clear.
// busy_o stays high for exactly 2**ADDR_SPACE cycles per sweep.
module tape_ram_init_ctrl
   import tape_ram_pkg::*;
#(
   parameter int ADDR_SPACE = 14
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   output logic                  busy_o,
   output logic                  sweep_we_o,
   output logic [ADDR_SPACE-1:0] sweep_addr_o
);

   state_e                state_q, state_d;
   logic [ADDR_SPACE-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (clr_i) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign busy_o       = (state_q == ST_INIT);
   assign sweep_we_o   = busy_o;
   assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/tape_ram_dp.sv
// Dual-port tape memory: port A read/write with byte strobes, port B read.
// Selectable read-during-write policy and optional output register.
module tape_ram_dp
   import tape_ram_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_SPACE = 14,
   parameter int                    BYTE_W     = 8,
   parameter int                    RDW_MODE   = 0,
   parameter int                    OUT_REG    = 0,
   parameter logic [DATA_WIDTH-1:0] BLANK      = '0
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr,
   input  logic                           a_en,
   input  logic [DATA_WIDTH/BYTE_W-1:0]   a_we,
   input  logic [ADDR_SPACE-1:0]          a_addr,
   input  logic [DATA_WIDTH-1:0]          a_wdata,
   output logic [DATA_WIDTH-1:0]          a_rdata,
   input  logic                           b_en,
   input  logic [ADDR_SPACE-1:0]          b_addr,
   output logic [DATA_WIDTH-1:0]          b_rdata,
   output logic                           busy
);

   localparam int NB    = DATA_WIDTH / BYTE_W;
   localparam int DEPTH = 2 ** ADDR_SPACE;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  sw_we;
   logic [ADDR_SPACE-1:0] sw_addr;
   logic                  a_go, b_go, a_wr, b_hit;
   logic [DATA_WIDTH-1:0] we_mask;
   logic [DATA_WIDTH-1:0] a_old, b_old, a_new;
   logic [DATA_WIDTH-1:0] a_rd_d, a_rd_q;
   logic [DATA_WIDTH-1:0] b_rd_d, b_rd_q;

   tape_ram_init_ctrl #(
      .ADDR_SPACE(ADDR_SPACE)
   ) u_init (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr),
      .busy_o      (busy),
      .sweep_we_o  (sw_we),
      .sweep_addr_o(sw_addr)
   );

   for (genvar i = 0; i < NB; i++) begin : g_mask
      assign we_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{a_we[i]}};
   end

   assign a_go  = a_en & ~busy & rst_n;
   assign b_go  = b_en & ~busy & rst_n;
   assign a_wr  = a_go & (|a_we);
   assign b_hit = a_wr & (a_addr == b_addr);
   assign a_old = mem_q[a_addr];
   assign b_old = mem_q[b_addr];
   assign a_new = DATA_WIDTH'(merge_word(MAX_DW'(a_old),
                                         MAX_DW'(a_wdata),
                                         MAX_DW'(we_mask)));

   always_comb begin
      a_rd_d = a_old;
      b_rd_d = b_old;
      if (RDW_MODE == RDW_WRITE_FIRST) begin
         a_rd_d = a_new;
         if (b_hit) b_rd_d = a_new;
      end
   end

   // Sweep and port A writes never coincide: port A is gated by busy
   always_ff @(posedge clk) begin
      if (sw_we)
         mem_q[sw_addr] <= BLANK;
      else if (a_wr)
         mem_q[a_addr] <= a_new;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_rd_q <= '0;
         b_rd_q <= '0;
      end else begin
         if (a_go) a_rd_q <= a_rd_d;
         if (b_go) b_rd_q <= b_rd_d;
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic                  a_v_q, b_v_q;
      logic [DATA_WIDTH-1:0] a_o_q, b_o_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            a_v_q <= 1'b0;
            b_v_q <= 1'b0;
            a_o_q <= '0;
            b_o_q <= '0;
         end else begin
            a_v_q <= a_go;
            b_v_q <= b_go;
            if (a_v_q) a_o_q <= a_rd_q;
            if (b_v_q) b_o_q <= b_rd_q;
         end
      end

      assign a_rdata = a_o_q;
      assign b_rdata = b_o_q;
   end else begin : g_noreg
      assign a_rdata = a_rd_q;
      assign b_rdata = b_rd_q;
   end

endmodule

// File: doc/tape_ram_dp.md
Name: tape_ram_dp

Overview:
Parametrised successor to the single-port tape memory used by the Turing-machine datapath.
- Port A is read/write with per-byte write enables; port B is read-only for a second head or debug observer.
- A selectable read-during-write policy and an optional output register are provided.
- A built-in init sweep fills every cell with a BLANK symbol after reset or on request, so the tape starts in a defined state.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_W
ADDR_SPACE, 14, address bits; depth = 2**ADDR_SPACE
BYTE_W, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_W
RDW_MODE, 0, same-address read during write: 0 = read-first (old data), 1 = write-first (merged new data)
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, latency 2
BLANK, 0, DATA_WIDTH-bit value written to every cell by the init sweep

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
clr  in  1  one-cycle pulse; restarts the init sweep (honoured only in IDLE)
a_en  in  1  port A access enable
a_we  in  NB  port A byte write enables, bit i covers data[i*BYTE_W +: BYTE_W]
a_addr  in  ADDR_SPACE  port A address
a_wdata  in  DATA_WIDTH  port A write data
a_rdata  out  DATA_WIDTH  port A read data
b_en  in  1  port B read enable
b_addr  in  ADDR_SPACE  port B address
b_rdata  out  DATA_WIDTH  port B read data
busy  out  1  high while the init sweep runs; port requests are ignored

Behaviour:
- Reset (rst_n=0 at an edge):
  - a_rdata=0, b_rdata=0 and any OUT_REG stages=0.
  - Sweep counter=0, state=INIT, busy=1 from the first edge after reset.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- FSM states: INIT, IDLE.
  - INIT: each cycle writes BLANK to mem[cnt] and increments cnt. When cnt = 2**ADDR_SPACE-1, it performs the last write and moves to IDLE. The sweep takes exactly 2**ADDR_SPACE cycles.
  - IDLE: busy=0. clr=1 moves to INIT with cnt=0; the cycle carrying clr is not itself a sweep write. clr is ignored during INIT.
- While busy=1:
  - a_en, b_en, a_we and clr are ignored.
  - a_rdata and b_rdata hold their last value.
  - No request is queued; the user must wait for busy=0.
- Port A (IDLE, a_en=1):
  - For each i with a_we[i]=1, lane i of mem[a_addr] takes a_wdata lane i. Other lanes are unchanged.
  - a_rdata is registered at the same edge:
    - a_we=0 or RDW_MODE=0: old word.
    - RDW_MODE=1: merged word, i.e. a_wdata lanes where we=1, old lanes elsewhere.
  - a_en=0: no write, a_rdata holds.
- Port B (IDLE, b_en=1):
  - b_rdata <= mem[b_addr].
  - If port A writes b_addr in the same cycle, b_rdata follows the same RDW_MODE rule.
  - b_en=0: b_rdata holds.
- Latency:
  - OUT_REG=0: data is visible the cycle after the enable.
  - OUT_REG=1: a second register stage is added, which also holds when its enable (the enable delayed one cycle) is low.
- Addresses wrap naturally; there is no out-of-range case.
- Widths: the sweep counter is ADDR_SPACE+1 bits or uses an explicit terminal compare; no lane arithmetic beyond the slice index.

Decomposition:
- Package tape_ram_pkg:
  - state typedef {ST_INIT, ST_IDLE};
  - constants RDW_READ_FIRST=0, RDW_WRITE_FIRST=1;
  - a function computing the byte-merged word (old, new, we).
- Natural sub-module: tape_ram_init_ctrl. It contains the FSM and sweep counter and outputs busy, the sweep write address and the sweep write strobe.
- The memory array and port muxing stay in the top module.

Test Plan:
- Bench config for all scenarios: DATA_WIDTH=32, BYTE_W=8, ADDR_SPACE=4, BLANK=32'hDEAD_BEEF.
- Reset: rst_n low 2 cycles then high -> busy=1 for exactly 16 cycles, then 0. Read all 16 addresses on A and B -> every word DEAD_BEEF. During busy, a_en=1/a_we=4'hF to addr 3 -> no effect.
- Byte enables: write 32'h11223344 to addr 5 with a_we=4'b0101 -> subsequent read returns 32'hDE22BE44.
- RDW: A writes 32'hCAFEF00D with we=4'hF to addr 7 while B reads addr 7 in the same cycle.
  - RDW_MODE=0: a_rdata=b_rdata=DEAD_BEEF.
  - RDW_MODE=1: both 32'hCAFEF00D.
- OUT_REG=1: read addr 5 at cycle t -> data appears at t+2, not t+1. With en low afterwards, outputs hold.
- Clear: after writes, pulse clr -> busy for 16 cycles, all cells read DEAD_BEEF. Assert rst_n=0 at sweep cycle 8 -> sweep restarts, busy lasts 16 cycles from release.
